cpu_sequencer: RTL

- Multi-cycle instruction sequencer for the 4-bit-opcode CPU. Drives the 3-bit `state` bus consumed by the control unit, which decodes on the negedge while state==3'b001.
- Owns the instruction-memory and data-memory request/ready handshakes, instruction-register load, PC-update strobe, halt, and a wait-timeout fault.
- Sits between the memories and the control unit/datapath.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/cpu_sequencer_wait_timer.sv | 37 +++
 rtl/cpu_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encodings, opcode constants, opcode classes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The control unit decodes while the sequencer sits in ST_DECODE, so that state
// is fixed at 3'b001. Encoding 3'b101 is unused. The control unit should use the
// OP_* constants below rather than its own literals.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'b000,
    ST_DECODE    = 3'b001,
    ST_EXECUTE   = 3'b010,
    ST_MEMORY    = 3'b011,
    ST_WRITEBACK = 3'b100,
    ST_HALT      = 3'b110,
    ST_FAULT     = 3'b111
  } state_e;

  // Opcodes 0..OP_ALU_MAX are register-to-register ALU operations.
  localparam logic [3:0] OP_ALU_MAX = 4'd10;
  localparam logic [3:0] OP_LOAD    = 4'd11;
  localparam logic [3:0] OP_STORE   = 4'd12;
  localparam logic [3:0] OP_BEQ     = 4'd13;
  localparam logic [3:0] OP_BNE     = 4'd14;
  localparam logic [3:0] OP_JUMP    = 4'd15;

  // Routing class used by the sequencer in EXECUTE.
  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_CTRL    // branches and jump: retire in EXECUTE
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    if (op <= OP_ALU_MAX)     cls = CLS_ALU;
    else if (op == OP_LOAD)   cls = CLS_LOAD;
    else if (op == OP_STORE)  cls = CLS_STORE;
    else                      cls = CLS_CTRL;
    return cls;
  endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Wait-state timer: counts cycles spent waiting on a memory ready.
// Latency: expired_o is combinational from the count and count_en_i.
// Backpressure: none; the owner decides when a wait is in progress.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clear_i      zero the count (takes priority over count_en_i)
//   count_en_i   a waiting cycle with ready low
//   expired_o    this waiting cycle is the MAX_WAIT-th in a row
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else if (clear_i) begin
      cnt_q <= 8'd0;
    end else if (count_en_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // The owner leaves the wait state on expiry, so the count never needs to saturate.
  assign expired_o = count_en_i && (cnt_q == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer driving the control-unit state bus and memory handshakes.
// Latency: ALU 4, load 5, store 4, branch/jump 3 cycles with ready on the first cycle.
// Backpressure: holds FETCH/MEMORY while ready is low; MAX_WAIT cycles of low ready park it in FAULT.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   op_code               opcode of the current IR (valid from DECODE on)
//   imem_ready/dmem_ready memory completion inputs, only honoured in FETCH/MEMORY
//   halt_req              stop at the next retire boundary
//   state                 current state (see cpu_pkg::state_e)
//   imem_req, ir_write, dmem_req, wb_en, pc_update, halted, fault   strobes decoded from state
//   instr_count           retired instructions, wraps
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op_code,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             wb_en,
  output logic             pc_update,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  op_class_e        cls;
  logic             waiting;
  logic             ready_sel;
  logic             expired;
  logic             retire;

  assign cls = op_class(op_code);

  // Only the ready belonging to the current wait state is looked at; strays are ignored.
  always_comb begin
    waiting   = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
    ready_sel = (state_q == ST_FETCH) ? imem_ready : dmem_ready;
  end

  // The timer restarts whenever we are outside a wait state or the wait completes,
  // so every entry into FETCH or MEMORY starts from zero.
  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (!waiting || ready_sel),
    .count_en_i (waiting && !ready_sel),
    .expired_o  (expired)
  );

  // Retire points: control ops in EXECUTE, stores when memory completes, everything else in WRITEBACK.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_EXECUTE:   retire = (cls == CLS_CTRL);
      ST_MEMORY:    retire = (cls == CLS_STORE) && dmem_ready;
      ST_WRITEBACK: retire = 1'b1;
      default:      retire = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready)   state_d = ST_DECODE;
        else if (expired) state_d = ST_FAULT;
      end
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (cls == CLS_ALU)                              state_d = ST_WRITEBACK;
        else if ((cls == CLS_LOAD) || (cls == CLS_STORE)) state_d = ST_MEMORY;
      end
      ST_MEMORY: begin
        if (dmem_ready)   state_d = ST_WRITEBACK;
        else if (expired) state_d = ST_FAULT;
      end
      ST_HALT: begin
        if (!halt_req) state_d = ST_FETCH;
      end
      ST_FAULT: state_d = ST_FAULT;
      // Unused encoding 3'b101: treat as a fault rather than run on.
      default:  state_d = ST_FAULT;
    endcase
    // Every retire path overrides the class routing above.
    if (retire) state_d = halt_req ? ST_HALT : ST_FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign imem_req    = (state_q == ST_FETCH);
  assign ir_write    = (state_q == ST_FETCH) && imem_ready;
  assign dmem_req    = (state_q == ST_MEMORY);
  assign wb_en       = (state_q == ST_WRITEBACK);
  assign pc_update   = retire;
  assign halted      = (state_q == ST_HALT);
  assign fault       = (state_q == ST_FAULT);
  assign instr_count = count_q;

endmodule
